// File: rtl/row_pixel_serializer.sv
// Pops one buffered row word and streams it out one pixel per valid/ready beat.
// Optional ROW_PIXEL_SERIALIZER_PREFETCH_EN reloads on the last beat for gapless rows.
module row_pixel_serializer #(
    parameter int unsigned DATA_WIDTH = 344,
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned ROWS       = 43
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      buf_empty,
    input  logic [DATA_WIDTH-1:0]     buf_rd_data,
    output logic                      buf_rd_en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [PIX_WIDTH-1:0]      m_data,
    output logic                      m_last,
    output logic                      m_frame_last,
    output logic [$clog2(ROWS)-1:0]   row_idx
);

    localparam int unsigned NPIX  = DATA_WIDTH / PIX_WIDTH;
    localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned ROW_W = $clog2(ROWS);

    generate
        if (DATA_WIDTH % PIX_WIDTH != 0) begin : g_width_check
            $error("DATA_WIDTH must be an integer multiple of PIX_WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [ROW_W-1:0]      row_q, row_d;

    logic is_last;
    logic beat;
    logic last_beat;
    logic load;

    always_comb begin
        is_last   = (state_q == StSend) && (pix_cnt_q == CNT_W'(NPIX - 1));
        beat      = (state_q == StSend) && m_ready;
        last_beat = is_last && m_ready;
`ifdef ROW_PIXEL_SERIALIZER_PREFETCH_EN
        load      = !buf_empty && ((state_q == StIdle) || last_beat);
`else
        load      = !buf_empty && (state_q == StIdle);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (last_beat) begin
                    state_d = load ? StSend : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            pix_cnt_q <= '0;
            row_q     <= '0;
        end else begin
            shift_q   <= shift_d;
            pix_cnt_q <= pix_cnt_d;
            row_q     <= row_d;
        end
    end

    always_comb begin
        shift_d   = shift_q;
        pix_cnt_d = pix_cnt_q;
        row_d     = row_q;
        if (load) begin
            shift_d   = buf_rd_data;
            pix_cnt_d = '0;
        end else if (beat) begin
            shift_d   = shift_q >> PIX_WIDTH;
            pix_cnt_d = is_last ? '0 : pix_cnt_q + 1'b1;
        end
        if (last_beat) begin
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end
    end

    // Output logic; the pop is gated by reset so no row is lost while held in reset
    always_comb begin
        m_valid      = (state_q == StSend);
        m_data       = shift_q[PIX_WIDTH-1:0];
        m_last       = is_last;
        m_frame_last = is_last && (row_q == ROW_W'(ROWS - 1));
        row_idx      = row_q;
        buf_rd_en    = load && rst_n;
    end

endmodule

// File: tb/tb_row_pixel_serializer.sv
// Directed self-checking bench for row_pixel_serializer with a single-entry buffer model.
module tb_row_pixel_serializer;

    localparam int unsigned DW   = 344;
    localparam int unsigned PW   = 8;
    localparam int unsigned ROWS = 43;
    localparam int unsigned NPIX = 43;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          buf_empty;
    logic [DW-1:0] buf_rd_data = '0;
    logic          buf_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [PW-1:0] m_data;
    logic          m_last;
    logic          m_frame_last;
    logic [5:0]    row_idx;

    logic          full = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int errors = 0;
    int checks = 0;
    int pops = 0;

    always #5 clk = ~clk;

    assign buf_empty = !full;

    // Write wins over a same-cycle pop, as in the real buffer
    always @(posedge clk) begin
        if (wr) begin
            full        <= 1'b1;
            buf_rd_data <= wr_data;
        end else if (buf_rd_en) begin
            full <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && buf_rd_en) pops <= pops + 1;
    end

    row_pixel_serializer #(
        .DATA_WIDTH (DW),
        .PIX_WIDTH  (PW),
        .ROWS       (ROWS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .buf_empty    (buf_empty),
        .buf_rd_data  (buf_rd_data),
        .buf_rd_en    (buf_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_frame_last (m_frame_last),
        .row_idx      (row_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_row(input logic [7:0] base);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NPIX); k++) r[k*PW +: PW] = base + 8'(k);
        return r;
    endfunction

    task automatic write_row(input logic [DW-1:0] w);
        wr      = 1'b1;
        wr_data = w;
        step();
        wr      = 1'b0;
    endtask

    // Write a row into an idle block and step through its load cycle
    task automatic load_row(input logic [DW-1:0] w);
        write_row(w);
        chk("load_rd_en", 32'(buf_rd_en), 1);
        chk("load_valid", 32'(m_valid), 0);
        step();
    endtask

    task automatic recv_row(input logic [7:0] base, input logic [5:0] exp_row, input bit alt,
                            input bit frame_row, input int wr_beat, input logic [7:0] wr_base);
        for (int k = 0; k < int'(NPIX); k++) begin
            m_ready = 1'b1;
            chk("valid", 32'(m_valid), 1);
            chk("data", 32'(m_data), 32'(8'(base + 8'(k))));
            chk("last", 32'(m_last), 32'(k == int'(NPIX) - 1));
            chk("frame_last", 32'(m_frame_last), 32'(frame_row && (k == int'(NPIX) - 1)));
            chk("row_idx", 32'(row_idx), 32'(exp_row));
            if (k == wr_beat) begin
                wr      = 1'b1;
                wr_data = make_row(wr_base);
            end
            step();
            wr = 1'b0;
            if (alt && (k < int'(NPIX) - 1)) begin
                m_ready = 1'b0;
                #1;
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_data", 32'(m_data), 32'(8'(base + 8'(k + 1))));
                chk("stall_last", 32'(m_last), 32'(k + 1 == int'(NPIX) - 1));
                step();
                chk("stall_hold", 32'(m_data), 32'(8'(base + 8'(k + 1))));
            end
        end
        m_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        step();
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_frame_last", 32'(m_frame_last), 0);
        chk("rst_row_idx", 32'(row_idx), 0);
        chk("rst_rd_en", 32'(buf_rd_en), 0);
        step();
        rst_n = 1'b1;

        // Empty buffer keeps the block idle
        for (int i = 0; i < 10; i++) begin
            chk("empty_rd_en", 32'(buf_rd_en), 0);
            chk("empty_valid", 32'(m_valid), 0);
            step();
        end

        // Single row 0x01..0x2B
        load_row(make_row(8'h01));
        recv_row(8'h01, 6'd0, 1'b0, 1'b0, -1, 8'h00);
        chk("single_idle", 32'(m_valid), 0);
        chk("single_row_idx", 32'(row_idx), 1);
        chk("single_pops", 32'(pops), 1);

        // Backpressure, ready alternating from the first beat
        load_row(make_row(8'h10));
        recv_row(8'h10, 6'd1, 1'b1, 1'b0, -1, 8'h00);
        chk("bp_row_idx", 32'(row_idx), 2);
        chk("bp_pops", 32'(pops), 2);

        // Two rows, second written during beat 10 of the first
        load_row(make_row(8'h40));
        recv_row(8'h40, 6'd2, 1'b0, 1'b0, 10, 8'h80);
`ifndef ROW_PIXEL_SERIALIZER_PREFETCH_EN
        chk("bubble_valid", 32'(m_valid), 0);
        chk("bubble_rd_en", 32'(buf_rd_en), 1);
        step();
`endif
        recv_row(8'h80, 6'd3, 1'b0, 1'b0, -1, 8'h00);
        chk("two_pops", 32'(pops), 4);
        chk("two_row_idx", 32'(row_idx), 4);

        // Reset asserted at beat 20 of a row
        load_row(make_row(8'h55));
        for (int k = 0; k < 20; k++) begin
            chk("pre_rst_data", 32'(m_data), 32'(8'(8'h55 + 8'(k))));
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_last", 32'(m_last), 0);
        chk("mid_rst_row_idx", 32'(row_idx), 0);
        chk("mid_rst_data", 32'(m_data), 0);
        chk("mid_rst_rd_en", 32'(buf_rd_en), 0);
        wr      = 1'b1;
        wr_data = make_row(8'h01);
        step();
        wr = 1'b0;
        chk("in_rst_rd_en", 32'(buf_rd_en), 0);
        step();
        chk("in_rst_rd_en2", 32'(buf_rd_en), 0);
        chk("in_rst_valid", 32'(m_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_rd_en", 32'(buf_rd_en), 1);
        chk("post_rst_valid", 32'(m_valid), 0);
        step();
        recv_row(8'h01, 6'd0, 1'b0, 1'b0, -1, 8'h00);
        chk("post_rst_pops", 32'(pops), 6);

        // Remaining rows of a 43-row frame
        for (int r = 1; r < int'(ROWS); r++) begin
            load_row(make_row(8'(r)));
            recv_row(8'(r), 6'(r), 1'b0, (r == int'(ROWS) - 1), -1, 8'h00);
        end
        chk("frame_wrap_row_idx", 32'(row_idx), 0);
        chk("frame_end_valid", 32'(m_valid), 0);
        chk("frame_pops", 32'(pops), 48);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/row_pixel_serializer.md
# row_pixel_serializer

Consumer-side reader for the single-entry row register buffer in the TSR CNN datapath. Whenever the buffer holds a row, it pops the whole 43-pixel row word in one cycle. It then emits the row one pixel per beat on a valid/ready stream toward the convolution input stage, and tracks row position within the frame.

## Interface

- DATA_WIDTH, 344, width of one buffered row word; must be an integer multiple of PIX_WIDTH (elaboration error otherwise)
- PIX_WIDTH, 8, width of one emitted pixel
- ROWS, 43, rows per frame
- NPIX (localparam), DATA_WIDTH/PIX_WIDTH, pixels per row (43 at defaults)

- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- buf_empty  input  1  buffer has no valid row when high
- buf_rd_data  input  DATA_WIDTH  buffered row; pixel k at bits [k*PIX_WIDTH +: PIX_WIDTH]
- buf_rd_en  output  1  pop pulse to buffer; combinational; forced 0 while rst_n low
- m_valid  output  1  m_data holds a valid pixel
- m_ready  input  1  downstream accepts the pixel this cycle
- m_data  output  PIX_WIDTH  current pixel
- m_last  output  1  current beat is pixel NPIX-1 of the row
- m_frame_last  output  1  m_last on row ROWS-1
- row_idx  output  clog2(ROWS)  index of the row being emitted / next to load

## Operation

- States: IDLE, SEND. Reset → IDLE.
- Reset values: m_valid 0, m_data 0, m_last 0, m_frame_last 0, row_idx 0, pixel counter 0, shift register 0.
- Load condition:
  - In IDLE, load when `!buf_empty`.
  - Load means: buf_rd_en = 1 for that cycle, buf_rd_data captured into the shift register, pix_cnt ← 0, state ← SEND.
- SEND behaviour:
  - m_valid = 1 and m_data = shift register [PIX_WIDTH-1:0].
  - A beat completes on m_valid & m_ready. On a beat, the shift register shifts right by PIX_WIDTH (zeros fill in at the top) and pix_cnt increments.
- Stall: m_valid & !m_ready keeps m_data, m_last, m_frame_last and pix_cnt stable. m_valid never drops before the beat completes.
- Flags:
  - m_last = (pix_cnt == NPIX-1) while in SEND.
  - m_frame_last = m_last & (row_idx == ROWS-1).
- Last beat (m_last & m_ready):
  - row_idx increments, wrapping from ROWS-1 to 0.
  - state ← IDLE, or as defined under Configuration.
- buf_rd_en is asserted only in load cycles, so exactly one pop per row. The buffer's simultaneous write-and-read is legal: the new data appears next cycle and empty stays low.
- When m_valid = 0, the value of m_data is not specified.

## Timing

- Load-to-first-pixel: m_valid rises the cycle after the buf_rd_en pulse.
- Row duration with m_ready held high: NPIX consecutive beats.
- Without the macro: m_valid is low for exactly one cycle between back-to-back rows (the IDLE load cycle).
- Reset asserted mid-row: outputs return to reset values immediately. The partially sent row is discarded and is not re-read. After release, the next load starts at pixel 0 and row_idx 0.
- buf_empty is sampled only in load-eligible cycles. If it stays high, the block stays in IDLE with buf_rd_en = 0.

## Configuration

- Macro: ROW_PIXEL_SERIALIZER_PREFETCH_EN
- Defined: on the last beat (m_last & m_ready), if `!buf_empty`, the load happens in the same cycle. buf_rd_en pulses, the shift register is reloaded, pix_cnt ← 0, and the state stays in SEND. Pixel 0 of the next row appears the following cycle, with zero bubble between rows. If buf_empty is high on the last beat, the state goes to IDLE as usual.
- Undefined: a load occurs only from IDLE, giving a one-cycle bubble per row as described above.

## Test plan

- Single row, bytes 0x01..0x2B (pixel k = k+1), m_ready = 1: one buf_rd_en pulse. Beats 0x01..0x2B follow on 43 consecutive cycles, m_last only on 0x2B, and row_idx goes 0→1.
- Backpressure, m_ready alternating 1/0 from the first beat: m_data stays stable across every stalled cycle. All 43 values arrive in order with no duplicates.
- Two rows, second written into the buffer during beat 10 of the first, m_ready = 1: without the macro there is exactly 1 cycle with m_valid = 0 between 0x2B and the next row's pixel 0. With the macro there are 0 idle cycles and 86 contiguous beats.
- 43 rows streamed: m_frame_last is high only on beat 43 of row 42. row_idx then reads 0.
- rst_n pulsed low at beat 20 of a row: m_valid, m_last and row_idx drop to 0 asynchronously, and buf_rd_en stays 0 during reset. A fresh row after release starts at 0x01.
- buf_empty held high for 10 cycles after reset: buf_rd_en = 0 and m_valid = 0 throughout.
